// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_*) carried on the 3-bit op field
//   - FSM state encoding (state_t) for alu_seq, also exported on its debug port
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//
// Handshake rules (both channels): a transfer happens at a rising clk edge
// where valid and ready are both 1. The producer holds its payload stable
// while valid=1 and ready=0; ready may be asserted independently of valid.
//
// Signals:
//   in_valid/in_ready    operand channel (a, b, op)
//   out_valid/out_ready  result channel (result, overflow, zero)
// Modports:
//   master  operand producer / result consumer (testbench, datapath)
//   slave   the ALU itself
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, overflow, zero
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      load a/b, clear accumulator and counter (single-cycle pulse)
//   a, b       operands, sampled when start=1
//   busy       a multiplication is in progress
//   done       combinational: the step taken at the coming edge is the last one
//   product    accumulator value including the current step; the full
//              2*WIDTH-bit product while done=1
//
// Timing: start at edge E0, steps at E1..E(WIDTH); done is high during the
// cycle before E(WIDTH) so the consumer can register product at that edge.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_step;

  // Partial product for the multiplier bit currently in the LSB.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST_STEP);
  assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   bus         alu_seq_if.slave: operand channel (in_valid/in_ready, a, b,
//               op) and result channel (out_valid/out_ready, result,
//               overflow, zero)
//   dbg_state   current FSM state
//
// Ops: ADD, SUB, SLT (signed), AND, OR, XOR, NOR complete one cycle after
// accept. MUL is a WIDTH-step shift-add (alu_mul_seq) that completes WIDTH+1
// cycles after accept.
//
// Build option ALU_SEQ_MUL_EN: when undefined, no multiplier is built and
// op MUL completes in one cycle with result=0, overflow=1, zero=1.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output state_t     dbg_state
);

  localparam int MSB = WIDTH - 1;

  // A mis-parameterised instance never accepts work.
  localparam bit CFG_OK = (WIDTH >= 2) && (CNT_W == $clog2(WIDTH + 1));

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;

  // Single-cycle datapath.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef ALU_SEQ_MUL_EN
      // Handled by the multiplier; this path is never registered for MUL.
      OP_MUL: alu_res = '0;
`else
      // No multiplier: flag the op as illegal.
      OP_MUL: begin
        alu_res = '0;
        alu_ovf = 1'b1;
      end
`endif
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            zero_d   = (alu_res == '0);
            state_d  = S_DONE;
          end
`else
          result_d = alu_res;
          ovf_d    = alu_ovf;
          zero_d   = (alu_res == '0);
          state_d  = S_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          result_d = mul_product[WIDTH-1:0];
          ovf_d    = |mul_product[2*WIDTH-1:WIDTH];
          zero_d   = (mul_product[WIDTH-1:0] == '0);
          state_d  = S_DONE;
        end else if (!mul_busy) begin
          // Multiplier idle without finishing: nothing to wait for.
          state_d = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && CFG_OK;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=8) against an
// integer-arithmetic reference model. Follows ALU_SEQ_MUL_EN for MUL.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     failures;

  // {overflow, zero, result}
  logic [W+1:0] exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb,
                                         input logic [2:0] mop);
    int sa, sb, ua, ub, s, p;
    logic [W-1:0] r;
    logic v;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = int'(ma);
    ub = int'(mb);
    r = '0;
    v = 1'b0;
    s = 0;
    p = 0;
    case (mop)
      3'd0: begin s = sa + sb; r = W'(ua + ub); v = (s > 127) || (s < -128); end
      3'd1: begin s = sa - sb; r = W'(ua - ub); v = (s > 127) || (s < -128); end
      3'd2: r = (sa < sb) ? W'(1) : W'(0);
`ifdef ALU_SEQ_MUL_EN
      3'd3: begin p = ua * ub; r = W'(p); v = (p > 255); end
`else
      3'd3: begin r = '0; v = 1'b1; end
`endif
      3'd4: r = ma & mb;
      3'd5: r = ma | mb;
      3'd6: r = ma ^ mb;
      default: r = ~(ma | mb);
    endcase
    return {v, (r == '0), r};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle. Issues one op, waits for the
  // result (bounded), holds it for `hold` cycles with junk on the operand
  // channel, then consumes it.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [2:0] top, input int hold);
    logic [W+1:0] exp;
    int lat;
    int exp_lat;
    exp_lat = (top == OP_MUL) ? MUL_LAT : 1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = ta;
    bus.b = tbv;
    bus.op = top;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(ta, tbv, top));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.a  = W'($urandom);
      bus.b  = W'($urandom);
      bus.op = 3'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'(bus.result), 32'(exp[W-1:0]));
      bus.in_valid = 1'b1;
      bus.a  = W'($urandom);
      bus.b  = W'($urandom);
      bus.op = 3'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    check("result", 32'(bus.result), 32'(exp[W-1:0]));
    check("overflow", 32'(bus.overflow), 32'(exp[W+1]));
    check("zero", 32'(bus.zero), 32'(exp[W]));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // ADD/SUB basics and overflow corners
    run_op(8'h81, 8'h01, OP_ADD, 0);
    run_op(8'h81, 8'h01, OP_SUB, 0);
    run_op(8'h7F, 8'h01, OP_ADD, 0);
    run_op(8'h80, 8'h01, OP_SUB, 0);
    run_op(8'h03, 8'hFF, OP_SUB, 0);
    // Logic ops
    run_op(8'hD8, 8'h1B, OP_AND, 0);
    run_op(8'hD8, 8'h1B, OP_OR,  0);
    run_op(8'hD8, 8'h1B, OP_XOR, 0);
    run_op(8'hD8, 8'h1B, OP_NOR, 0);
    run_op(8'h55, 8'h55, OP_XOR, 0);
    // MUL and SLT
    run_op(8'h0F, 8'h11, OP_MUL, 0);
    run_op(8'h10, 8'h10, OP_MUL, 0);
    run_op(8'hFF, 8'hFF, OP_MUL, 0);
    run_op(8'h80, 8'h01, OP_SLT, 0);
    run_op(8'h01, 8'h80, OP_SLT, 0);
    // Backpressure: result held 5 cycles
    run_op(8'hA5, 8'h3C, OP_ADD, 5);
    run_op(8'h12, 8'h34, OP_MUL, 5);
    run_op(8'h80, 8'h01, OP_SLT, 0);

    // Reset during MUL cycle 4 (or during a pending result without MUL)
    bus.a = 8'h37;
    bus.b = 8'h5B;
    bus.op = OP_MUL;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_result", 32'(bus.result), 32'd0);
    check("mrst_overflow", 32'(bus.overflow), 32'd0);
    check("mrst_zero", 32'(bus.zero), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("mrst_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Random ops
    for (int n = 0; n < 60; n++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
